// File: rtl/slt_exec_stage.sv
// slt_exec_stage: two-stage valid/ready execute stage for SLT/SLTU/SLTI/SLTIU.
//   S1 registers the operands: A = rs1, B = rs2 or the sign-extended imm12.
//   S2 registers the 1-bit less-than result and rd for writeback.
// Ports:
//   I_CLK, I_RST (async, active-high)
//   issue side     : I_VALID / O_READY, I_RS1, I_RS2, I_IMM12, I_USE_IMM, I_U, I_RD
//   control        : I_FLUSH drops everything in flight at the next edge
//   writeback side : O_WB_VALID / I_WB_READY, O_WB_DATA, O_WB_RD, O_WB_WE
// slt_sltu_32bit: combinational signed/unsigned 32-bit less-than.

module slt_sltu_32bit (
  input  logic [31:0] I_OP_A,
  input  logic [31:0] I_OP_B,
  input  logic        I_U,
  output logic        O_Result
);

  // Unsigned compare, or signed compare on the two's-complement view.
  always_comb begin
    O_Result = 1'b0;
    if (I_U) O_Result = (I_OP_A < I_OP_B);
    else     O_Result = ($signed(I_OP_A) < $signed(I_OP_B));
  end

endmodule

module slt_exec_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic                  I_VALID,
  output logic                  O_READY,
  input  logic [XLEN-1:0]       I_RS1,
  input  logic [XLEN-1:0]       I_RS2,
  input  logic [11:0]           I_IMM12,
  input  logic                  I_USE_IMM,
  input  logic                  I_U,
  input  logic [REG_ADDR_W-1:0] I_RD,
  input  logic                  I_FLUSH,
  output logic                  O_WB_VALID,
  input  logic                  I_WB_READY,
  output logic [XLEN-1:0]       O_WB_DATA,
  output logic [REG_ADDR_W-1:0] O_WB_RD,
  output logic                  O_WB_WE
);

  localparam int unsigned IMM_W = 12;

  logic                  s1_valid;
  logic [XLEN-1:0]       s1_op_a;
  logic [XLEN-1:0]       s1_op_b;
  logic                  s1_u;
  logic [REG_ADDR_W-1:0] s1_rd;

  logic                  s2_valid;
  logic                  s2_result;
  logic [REG_ADDR_W-1:0] s2_rd;

  logic                  s2_free;
  logic                  s1_adv;
  logic                  accept;
  logic                  cmp_lt;
  logic [XLEN-1:0]       op_b_sel;

  // Handshake: S2 frees when empty or drained; S1 moves when S2 is free.
  assign s2_free  = !s2_valid || I_WB_READY;
  assign s1_adv   = s1_valid && s2_free;
  assign O_READY  = !s1_valid || s2_free;
  assign accept   = I_VALID && O_READY;

  // Immediate is sign-extended before capture, so SLTIU sees e.g. 0xFFF as 0xFFFFFFFF.
  assign op_b_sel = I_USE_IMM ? {{(XLEN-IMM_W){I_IMM12[IMM_W-1]}}, I_IMM12} : I_RS2;

  slt_sltu_32bit u_cmp (
    .I_OP_A   (s1_op_a),
    .I_OP_B   (s1_op_b),
    .I_U      (s1_u),
    .O_Result (cmp_lt)
  );

  // S1: operand registers; flush beats a same-cycle accept.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      s1_valid <= 1'b0;
      s1_op_a  <= '0;
      s1_op_b  <= '0;
      s1_u     <= 1'b0;
      s1_rd    <= '0;
    end else begin
      if (I_FLUSH)     s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (accept) begin
        s1_op_a <= I_RS1;
        s1_op_b <= op_b_sel;
        s1_u    <= I_U;
        s1_rd   <= I_RD;
      end
    end
  end

  // S2: result register; holds while writeback stalls.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      s2_valid  <= 1'b0;
      s2_result <= 1'b0;
      s2_rd     <= '0;
    end else begin
      if (I_FLUSH)                     s2_valid <= 1'b0;
      else if (s1_adv)                 s2_valid <= 1'b1;
      else if (s2_valid && I_WB_READY) s2_valid <= 1'b0;

      if (s1_adv) begin
        s2_result <= cmp_lt;
        s2_rd     <= s1_rd;
      end
    end
  end

  assign O_WB_VALID = s2_valid;
  assign O_WB_DATA  = {(XLEN-1)'(0), s2_result};
  assign O_WB_RD    = s2_rd;
  assign O_WB_WE    = s2_valid && (s2_rd != '0);

endmodule
